fetch_sequencer: RTL and testbench

//  Controls instruction fetch for the single-cycle-to-multicycle MIPS core.

---
 rtl/fetch_sequencer_if.sv | 11 +
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready bus between the fetch sequencer and imem.
// The master drives the request and address; the slave answers with ready/rdata.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch control for the multicycle MIPS core: owns the PC, issues one imem request
// at a time, and holds each fetched word in a single valid/stall slot for decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_sequencer_if.master         imem,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [31:0]               instr_pc,
  output logic [31:0]               pc_plus4,
  output logic                      fetch_error
);

  typedef enum logic [1:0] {BOOT, REQ, VALID, ERROR} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [7:0]  wait_cnt, wait_n;
  logic        pend, pend_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] instr_n, instr_pc_n;
  logic        redir_bad;

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      wait_cnt <= 8'd0;
      pend     <= 1'b0;
      pend_pc  <= 32'd0;
      instr    <= 32'd0;
      instr_pc <= 32'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      wait_cnt <= wait_n;
      pend     <= pend_n;
      pend_pc  <= pend_pc_n;
      instr    <= instr_n;
      instr_pc <= instr_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    wait_n     = wait_cnt;
    pend_n     = pend;
    pend_pc_n  = pend_pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    // A misaligned target is fatal from any state and leaves the PC untouched.
    if (redir_bad) begin
      state_n = ERROR;
    end else begin
      unique case (state)
        BOOT: begin
          state_n = REQ;
          if (redirect_valid) pc_n = redirect_pc;
        end
        REQ: begin
          if (imem.imem_ready) begin
            wait_n = 8'd0;
            if (redirect_valid) begin
              pc_n   = redirect_pc;
              pend_n = 1'b0;
            end else if (pend) begin
              pc_n   = pend_pc;
              pend_n = 1'b0;
            end else begin
              instr_n    = imem.imem_rdata;
              instr_pc_n = pc;
              pc_n       = pc + 32'd4;
              state_n    = VALID;
            end
          end else begin
            // The outstanding request is never aborted; remember the newest target.
            if (redirect_valid) begin
              pend_n    = 1'b1;
              pend_pc_n = redirect_pc;
            end
            if (wait_cnt == 8'(MAX_WAIT - 1)) state_n = ERROR;
            else                              wait_n  = wait_cnt + 8'd1;
          end
        end
        VALID: begin
          if (redirect_valid) begin
            pc_n    = redirect_pc;
            state_n = REQ;
          end else if (!stall) begin
            state_n = REQ;
          end
        end
        ERROR: state_n = ERROR;
        default: state_n = ERROR;
      endcase
    end
  end

  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == VALID);
  assign fetch_error    = (state == ERROR);
  assign pc_plus4       = instr_pc + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a flag-based behavioural model of the fetch
// protocol predicts every output each cycle; segments vary memory/decode behaviour.
module tb_fetch_sequencer;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid, fetch_error;
  logic [31:0] instr, instr_pc, pc_plus4;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .imem(bus.master), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_plus4(pc_plus4), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Behavioural model: "booting", "holding an instruction", "dead", otherwise fetching.
  bit          m_boot, m_have, m_dead, m_pend;
  logic [31:0] m_pc, m_pend_pc, m_instr, m_ipc;
  int          m_wait;

  task automatic model_reset();
    m_boot = 1; m_have = 0; m_dead = 0; m_pend = 0;
    m_pc = 32'h0; m_pend_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_wait = 0;
  endtask

  task automatic model_step(input bit rdy, input bit stl, input bit rv, input logic [31:0] rpc);
    if (m_dead) return;
    if (rv && rpc[1:0] != 2'b00) begin
      m_dead = 1; m_have = 0;
    end else if (m_boot) begin
      m_boot = 0;
      if (rv) m_pc = rpc;
    end else if (m_have) begin
      if (rv) begin m_have = 0; m_pc = rpc; end
      else if (!stl) m_have = 0;
    end else if (rdy) begin
      m_wait = 0;
      if (rv)          begin m_pc = rpc; m_pend = 0; end
      else if (m_pend) begin m_pc = m_pend_pc; m_pend = 0; end
      else begin
        m_instr = mem_word(m_pc); m_ipc = m_pc; m_pc = m_pc + 32'd4; m_have = 1;
      end
    end else begin
      if (rv) begin m_pend = 1; m_pend_pc = rpc; end
      m_wait++;
      if (m_wait >= MAX_WAIT) m_dead = 1;
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".imem_req"},    32'(bus.imem_req), 32'(!m_boot && !m_dead && !m_have));
    chk({pfx, ".imem_addr"},   bus.imem_addr, m_pc);
    chk({pfx, ".instr_valid"}, 32'(instr_valid), 32'(m_have));
    chk({pfx, ".instr"},       instr, m_instr);
    chk({pfx, ".instr_pc"},    instr_pc, m_ipc);
    chk({pfx, ".pc_plus4"},    pc_plus4, m_ipc + 32'd4);
    chk({pfx, ".fetch_error"}, 32'(fetch_error), 32'(m_dead));
  endtask

  function automatic logic [31:0] pick_target(input int bad_pm);
    logic [31:0] t;
    case ($urandom_range(0, 4))
      0: t = 32'h0000_0100;
      1: t = 32'hFFFF_FFFC;
      2: t = 32'hFFFF_FFF8;
      default: t = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endcase
    if ($urandom_range(0, 999) < bad_pm) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    bit          rdy, stl, rv;
    logic [31:0] rpc;
    int rdy_pct, stl_pct, rv_pct, bad_pm;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'd0;
    model_reset();
    for (int seg = 0; seg < 14; seg++) begin
      case (seg)
        0:  begin rdy_pct = 100; stl_pct = 0;  rv_pct = 0;  bad_pm = 0;  end
        1:  begin rdy_pct = 25;  stl_pct = 0;  rv_pct = 0;  bad_pm = 0;  end
        2:  begin rdy_pct = 100; stl_pct = 80; rv_pct = 0;  bad_pm = 0;  end
        3:  begin rdy_pct = 30;  stl_pct = 30; rv_pct = 25; bad_pm = 0;  end
        4:  begin rdy_pct = 0;   stl_pct = 0;  rv_pct = 10; bad_pm = 0;  end
        5:  begin rdy_pct = 60;  stl_pct = 40; rv_pct = 10; bad_pm = 30; end
        default: begin
          rdy_pct = $urandom_range(20, 100); stl_pct = $urandom_range(0, 70);
          rv_pct  = $urandom_range(0, 30);   bad_pm  = $urandom_range(0, 15);
        end
      endcase
      // Reset lands between edges, possibly with a request outstanding.
      @(negedge clk);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 150; c++) begin
        check_all("run");
        rdy = ($urandom_range(0, 99) < rdy_pct);
        stl = ($urandom_range(0, 99) < stl_pct);
        rv  = ($urandom_range(0, 99) < rv_pct);
        rpc = pick_target(bad_pm);
        bus.imem_ready = rdy;
        bus.imem_rdata = mem_word(m_pc);
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        model_step(rdy, stl, rv, rpc);
        @(negedge clk);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
